// File: rtl/face_box_overlay.sv
// face_box_overlay: draws a solid-colour rectangular outline on an RGB565
// stream around the detector's bounding box. The box is latched at each
// frame start and drawn on the frame that follows it. A short coast window
// keeps the last box on screen when detection drops out. The stream passes
// through a two-stage pipeline, so data and syncs come out exactly 2 clk late.
//
// Handshake: per_frame_clken is a one-cycle pixel-valid strobe qualified by
// per_frame_href. There is no back-pressure; every strobe is consumed, and
// the post_* outputs replay the same strobe pattern 2 clk later.
module face_box_overlay #(
  parameter int          H_ACT       = 640,
  parameter int          V_ACT       = 480,
  parameter int          LINE_W      = 2,
  parameter logic [15:0] BOX_COLOR   = 16'hF800,
  parameter int          HOLD_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        per_frame_clken,
  input  logic [15:0] per_img_data,
  input  logic [11:0] x_min,
  input  logic [11:0] x_max,
  input  logic [11:0] y_min,
  input  logic [11:0] y_max,
  output logic        post_frame_vsync,
  output logic        post_frame_href,
  output logic        post_frame_clken,
  output logic [15:0] post_img_data,
  output logic        box_valid,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRACK = 2'd1,
    S_COAST = 2'd2
  } state_t;

  localparam logic [11:0] H_LAST = 12'(H_ACT - 1);
  localparam logic [11:0] V_LAST = 12'(V_ACT - 1);
  localparam logic [11:0] H_LIM  = 12'(H_ACT);
  localparam logic [11:0] V_LIM  = 12'(V_ACT);
  localparam logic [12:0] LW13   = 13'(LINE_W);
  localparam logic [3:0]  HOLD4  = 4'(HOLD_FRAMES);

  // Stage-1 registers; vsync_s1_q also serves as the delayed vsync for fs.
  logic        vsync_s1_q, href_s1_q, clken_s1_q;
  logic [15:0] data_s1_q;
  logic        in_x_q, in_y_q, edge_x_q, edge_y_q, act_q;

  logic [11:0] cnt_x_q, cnt_x_d;
  logic [11:0] cnt_y_q, cnt_y_d;

  state_t      state_q, state_d;
  logic [3:0]  miss_q, miss_d;
  logic [11:0] bx0_q, bx0_d, bx1_q, bx1_d, by0_q, by0_d, by1_q, by1_d;

  logic fs;
  logic det_ok;
  logic in_x_d, in_y_d, edge_x_d, edge_y_d;
  logic border;

  assign fs     = per_frame_vsync & ~vsync_s1_q;
  assign det_ok = (x_min <= x_max) && (y_min <= y_max) &&
                  (x_max < H_LIM) && (y_max < V_LIM);

  assign box_valid = (state_q != S_IDLE);
  assign dbg_state = state_q;

  // Pixel position: cleared at frame start (which wins over a same-cycle
  // strobe), advanced once per strobe with line and frame wrap.
  always_comb begin
    cnt_x_d = cnt_x_q;
    cnt_y_d = cnt_y_q;
    if (fs) begin
      cnt_x_d = '0;
      cnt_y_d = '0;
    end else if (per_frame_clken) begin
      if (cnt_x_q == H_LAST) begin
        cnt_x_d = '0;
        cnt_y_d = (cnt_y_q == V_LAST) ? 12'd0 : cnt_y_q + 12'd1;
      end else begin
        cnt_x_d = cnt_x_q + 12'd1;
      end
    end
  end

  // Box tracker next state: only a frame start can move it, so the latched
  // box is stable for the whole frame being drawn.
  always_comb begin
    state_d = state_q;
    miss_d  = miss_q;
    bx0_d   = bx0_q;
    bx1_d   = bx1_q;
    by0_d   = by0_q;
    by1_d   = by1_q;
    if (fs) begin
      case (state_q)
        S_IDLE: begin
          if (det_ok) begin
            miss_d  = 4'd0;
            state_d = S_TRACK;
          end
        end
        S_TRACK: begin
          if (!det_ok) begin
            if (HOLD4 == 4'd0) begin
              state_d = S_IDLE;
            end else begin
              miss_d  = 4'd1;
              state_d = S_COAST;
            end
          end
        end
        S_COAST: begin
          if (det_ok) begin
            miss_d  = 4'd0;
            state_d = S_TRACK;
          end else if (miss_q == HOLD4) begin
            state_d = S_IDLE;
          end else begin
            miss_d = miss_q + 4'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (det_ok) begin
        bx0_d = x_min;
        bx1_d = x_max;
        by0_d = y_min;
        by1_d = y_max;
      end
    end
  end

  // Border geometry for the pixel being presented; sums are 13 bit so the
  // thickness tests never wrap and never need a subtraction.
  always_comb begin
    in_x_d   = (cnt_x_q >= bx0_q) && (cnt_x_q <= bx1_q);
    in_y_d   = (cnt_y_q >= by0_q) && (cnt_y_q <= by1_q);
    edge_x_d = ({1'b0, cnt_x_q} < ({1'b0, bx0_q} + LW13)) ||
               (({1'b0, cnt_x_q} + LW13) > {1'b0, bx1_q});
    edge_y_d = ({1'b0, cnt_y_q} < ({1'b0, by0_q} + LW13)) ||
               (({1'b0, cnt_y_q} + LW13) > {1'b0, by1_q});
  end

  assign border = act_q & in_x_q & in_y_q & (edge_x_q | edge_y_q);

  // Counter and tracker state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_x_q <= '0;
      cnt_y_q <= '0;
      state_q <= S_IDLE;
      miss_q  <= '0;
      bx0_q   <= '0;
      bx1_q   <= '0;
      by0_q   <= '0;
      by1_q   <= '0;
    end else begin
      cnt_x_q <= cnt_x_d;
      cnt_y_q <= cnt_y_d;
      state_q <= state_d;
      miss_q  <= miss_d;
      bx0_q   <= bx0_d;
      bx1_q   <= bx1_d;
      by0_q   <= by0_d;
      by1_q   <= by1_d;
    end
  end

  // Stage 1: register the stream and the compare results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_s1_q <= 1'b0;
      href_s1_q  <= 1'b0;
      clken_s1_q <= 1'b0;
      data_s1_q  <= '0;
      in_x_q     <= 1'b0;
      in_y_q     <= 1'b0;
      edge_x_q   <= 1'b0;
      edge_y_q   <= 1'b0;
      act_q      <= 1'b0;
    end else begin
      vsync_s1_q <= per_frame_vsync;
      href_s1_q  <= per_frame_href;
      clken_s1_q <= per_frame_clken;
      data_s1_q  <= per_img_data;
      in_x_q     <= in_x_d;
      in_y_q     <= in_y_d;
      edge_x_q   <= edge_x_d;
      edge_y_q   <= edge_y_d;
      act_q      <= box_valid;
    end
  end

  // Stage 2: colour mux; blanked outside active lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
      post_img_data    <= '0;
    end else begin
      post_frame_vsync <= vsync_s1_q;
      post_frame_href  <= href_s1_q;
      post_frame_clken <= clken_s1_q;
      post_img_data    <= !href_s1_q ? 16'h0000 :
                          (border ? BOX_COLOR : data_s1_q);
    end
  end

endmodule

// File: tb/tb_face_box_overlay.sv
// Bench for face_box_overlay on a 16x8 raster. Two instances share the same
// stimulus: one with a 1-pixel outline, one with a 2-pixel outline, both
// with a two-frame coast window.
module tb_face_box_overlay;

  localparam int H = 16;
  localparam int V = 8;
  localparam logic [15:0] COL = 16'hF800;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vs = 1'b0, hr = 1'b0, ce = 1'b0;
  logic [15:0] din = '0;
  logic [11:0] xmn = '0, xmx = '0, ymn = '0, ymx = '0;

  logic        pv_a, ph_a, pc_a, bv_a;
  logic [15:0] pd_a;
  logic [1:0]  st_a;
  logic        pv_b, ph_b, pc_b, bv_b;
  logic [15:0] pd_b;
  logic [1:0]  st_b;

  int checks = 0;
  int errors = 0;

  face_box_overlay #(.H_ACT(H), .V_ACT(V), .LINE_W(1), .BOX_COLOR(COL), .HOLD_FRAMES(2)) u_a (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ce), .per_img_data(din),
    .x_min(xmn), .x_max(xmx), .y_min(ymn), .y_max(ymx),
    .post_frame_vsync(pv_a), .post_frame_href(ph_a), .post_frame_clken(pc_a),
    .post_img_data(pd_a), .box_valid(bv_a), .dbg_state(st_a)
  );

  face_box_overlay #(.H_ACT(H), .V_ACT(V), .LINE_W(2), .BOX_COLOR(COL), .HOLD_FRAMES(2)) u_b (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ce), .per_img_data(din),
    .x_min(xmn), .x_max(xmx), .y_min(ymn), .y_max(ymx),
    .post_frame_vsync(pv_b), .post_frame_href(ph_b), .post_frame_clken(pc_b),
    .post_img_data(pd_b), .box_valid(bv_b), .dbg_state(st_b)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [11:0] x0, x1, y0, y1;
    bit          fs_clk;
    bit          lat;
    bit          mid;
    logic        bv;
    logic [1:0]  st;
  } frame_t;

  typedef struct {
    int   fr, x, y;
    logic ea, eb;
  } pchk_t;

  frame_t frames[10];
  pchk_t  pt[35];

  logic [15:0] exp_q_a[$];
  logic [15:0] exp_q_b[$];

  // Capture of every output pixel, indexed by output frame and raster order.
  logic [15:0] cap_a[0:15][0:127];
  logic [15:0] cap_b[0:15][0:127];
  int   mon_frame = -1;
  int   mon_idx = 0;
  logic pv_prev = 1'b0;

  always @(negedge clk) begin
    if (pv_a && !pv_prev) begin
      mon_frame = mon_frame + 1;
      mon_idx = 0;
    end
    pv_prev = pv_a;
    if (pc_a && ph_a && mon_frame >= 0 && mon_frame < 16 && mon_idx < 128) begin
      cap_a[mon_frame][mon_idx] = pd_a;
      cap_b[mon_frame][mon_idx] = pd_b;
      mon_idx = mon_idx + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pix(input int x, input int y);
    return 16'(32'h1000 + y * 256 + x);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame start with given detector box; optionally with a pixel strobe in
  // the fs cycle and with a vsync latency check.
  task automatic do_fs(input logic [11:0] x0, x1, y0, y1, input bit with_clk, input bit lat);
    xmn = x0; xmx = x1; ymn = y0; ymx = y1;
    vs = 1'b1; ce = with_clk; hr = 1'b0; din = '0;
    tick();
    ce = 1'b0;
    if (lat) chk("vsync_lat1", pv_a, 0);
    tick();
    if (lat) chk("vsync_lat2", pv_a, 1);
    vs = 1'b0;
    tick();
  endtask

  task automatic run_frame(input frame_t f);
    if (f.fs_clk) begin
      ce = 1'b1; hr = 1'b0; din = '0;
      repeat (3) tick();
    end
    do_fs(f.x0, f.x1, f.y0, f.y1, f.fs_clk, f.lat);
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        if (x == 8) begin
          hr = 1'b1; ce = 1'b0; din = 16'hDEAD;
          tick();
        end
        if (f.mid && y == 3 && x == 0) begin
          xmn = 12'd0; xmx = 12'd15; ymn = 12'd0; ymx = 12'd7;
        end
        hr = 1'b1; ce = 1'b1; din = pix(x, y);
        tick();
        if (f.lat && y == 0 && x == 0) begin
          chk("href_lat1", ph_a, 0);
          chk("clken_lat1", pc_a, 0);
        end
        if (f.lat && y == 0 && x == 1) begin
          chk("href_lat2", ph_a, 1);
          chk("clken_lat2", pc_a, 1);
          chk("data_lat2", pd_a, pix(0, 0));
        end
      end
      hr = 1'b0; ce = 1'b0; din = '0;
      tick();
    end
    repeat (4) tick();
  endtask

  initial begin
    // Frame sequence: invalid, box with mid-frame detector change, narrow
    // box, three losses (coast 1, coast 2, drop), reacquire, loss, reload
    // during coast, fs coinciding with a pixel strobe.
    frames[0] = '{12'd16, 12'd0,  12'd0, 12'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
    frames[1] = '{12'd4,  12'd10, 12'd2, 12'd5, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1};
    frames[2] = '{12'd4,  12'd6,  12'd0, 12'd7, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1};
    frames[3] = '{12'd16, 12'd0,  12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2};
    frames[4] = '{12'd16, 12'd0,  12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2};
    frames[5] = '{12'd16, 12'd0,  12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};
    frames[6] = '{12'd4,  12'd10, 12'd2, 12'd5, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1};
    frames[7] = '{12'd16, 12'd0,  12'd0, 12'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2};
    frames[8] = '{12'd1,  12'd3,  12'd1, 12'd2, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1};
    frames[9] = '{12'd0,  12'd0,  12'd0, 12'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1};

    // {frame, x, y, border on 1-px instance, border on 2-px instance}
    pt[0]  = '{0, 4, 2, 1'b0, 1'b0};
    pt[1]  = '{0, 7, 3, 1'b0, 1'b0};
    pt[2]  = '{0, 0, 0, 1'b0, 1'b0};
    pt[3]  = '{1, 4, 2, 1'b1, 1'b1};
    pt[4]  = '{1, 7, 2, 1'b1, 1'b1};
    pt[5]  = '{1, 7, 3, 1'b0, 1'b1};
    pt[6]  = '{1, 5, 3, 1'b0, 1'b1};
    pt[7]  = '{1, 10, 4, 1'b1, 1'b1};
    pt[8]  = '{1, 11, 3, 1'b0, 1'b0};
    pt[9]  = '{1, 3, 3, 1'b0, 1'b0};
    pt[10] = '{1, 7, 5, 1'b1, 1'b1};
    pt[11] = '{1, 7, 6, 1'b0, 1'b0};
    pt[12] = '{1, 0, 7, 1'b0, 1'b0};
    pt[13] = '{1, 15, 7, 1'b0, 1'b0};
    pt[14] = '{1, 7, 1, 1'b0, 1'b0};
    pt[15] = '{2, 4, 3, 1'b1, 1'b1};
    pt[16] = '{2, 6, 3, 1'b1, 1'b1};
    pt[17] = '{2, 5, 0, 1'b1, 1'b1};
    pt[18] = '{2, 5, 7, 1'b1, 1'b1};
    pt[19] = '{2, 5, 3, 1'b0, 1'b1};
    pt[20] = '{2, 7, 3, 1'b0, 1'b0};
    pt[21] = '{2, 3, 0, 1'b0, 1'b0};
    pt[22] = '{3, 5, 3, 1'b0, 1'b1};
    pt[23] = '{3, 4, 3, 1'b1, 1'b1};
    pt[24] = '{4, 4, 3, 1'b1, 1'b1};
    pt[25] = '{5, 4, 3, 1'b0, 1'b0};
    pt[26] = '{6, 4, 2, 1'b1, 1'b1};
    pt[27] = '{7, 4, 2, 1'b1, 1'b1};
    pt[28] = '{7, 7, 3, 1'b0, 1'b1};
    pt[29] = '{8, 2, 1, 1'b1, 1'b1};
    pt[30] = '{8, 2, 2, 1'b1, 1'b1};
    pt[31] = '{8, 1, 1, 1'b1, 1'b1};
    pt[32] = '{8, 4, 2, 1'b0, 1'b0};
    pt[33] = '{9, 0, 0, 1'b1, 1'b1};
    pt[34] = '{9, 1, 0, 1'b0, 1'b0};

    // Reset state.
    repeat (3) tick();
    chk("rst_vsync", pv_a, 0);
    chk("rst_href", ph_a, 0);
    chk("rst_data", pd_a, 0);
    chk("rst_box_valid", bv_a, 0);
    chk("rst_state", st_a, 0);
    rst_n = 1'b1;
    tick();

    // Frames with box-tracker checks right after each frame.
    for (int i = 0; i < 10; i++) begin
      run_frame(frames[i]);
      chk($sformatf("box_valid_a_f%0d", i), bv_a, frames[i].bv);
      chk($sformatf("box_valid_b_f%0d", i), bv_b, frames[i].bv);
      chk($sformatf("state_a_f%0d", i), st_a, frames[i].st);
      chk($sformatf("state_b_f%0d", i), st_b, frames[i].st);
    end

    // Pixel scoreboard.
    foreach (pt[k]) begin
      exp_q_a.push_back(pt[k].ea ? COL : pix(pt[k].x, pt[k].y));
      exp_q_b.push_back(pt[k].eb ? COL : pix(pt[k].x, pt[k].y));
    end
    foreach (pt[k]) begin
      logic [15:0] ea, eb;
      ea = exp_q_a.pop_front();
      eb = exp_q_b.pop_front();
      chk($sformatf("pix_a_f%0d_x%0d_y%0d", pt[k].fr, pt[k].x, pt[k].y),
          cap_a[pt[k].fr][pt[k].y * H + pt[k].x], ea);
      chk($sformatf("pix_b_f%0d_x%0d_y%0d", pt[k].fr, pt[k].x, pt[k].y),
          cap_b[pt[k].fr][pt[k].y * H + pt[k].x], eb);
    end

    // Reset in the middle of an active frame.
    do_fs(12'd4, 12'd10, 12'd2, 12'd5, 1'b0, 1'b0);
    chk("midrst_pre_box_valid", bv_a, 1);
    hr = 1'b1; ce = 1'b1; din = 16'h1234;
    repeat (3) tick();
    chk("midrst_pre_href", ph_a, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_vsync", pv_a, 0);
    chk("midrst_href", ph_a, 0);
    chk("midrst_clken", pc_a, 0);
    chk("midrst_data_a", pd_a, 0);
    chk("midrst_data_b", pd_b, 0);
    chk("midrst_box_valid_a", bv_a, 0);
    chk("midrst_box_valid_b", bv_b, 0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("postrst_box_valid", bv_a, 0);
    chk("postrst_href", ph_a, 1);
    chk("postrst_data_a", pd_a, 16'h1234);
    chk("postrst_data_b", pd_b, 16'h1234);
    hr = 1'b0; ce = 1'b0; din = '0;
    do_fs(12'd16, 12'd0, 12'd0, 12'd0, 1'b0, 1'b0);
    chk("postrst_invalid_fs", bv_a, 0);
    do_fs(12'd4, 12'd10, 12'd2, 12'd5, 1'b0, 1'b0);
    chk("postrst_valid_fs_a", bv_a, 1);
    chk("postrst_valid_fs_b", bv_b, 1);
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
